k2_exec_controller: RTL and testbench

Execution controller for the K2 processor on the FPGA board. It replaces the free-running slowed clock with a single-cycle execution enable, `cpu_en`, on the system clock, and sequences the processor through halt, run, single-step, breakpoint and clear. Board switch and button inputs are synchronized and debounced inside the block. A 16-bit executed-instruction count is produced for the seven-segment controller.

---
 rtl/k2_exec_controller.sv | 157 +++++++++++++++
 tb/tb_k2_exec_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/k2_exec_controller.sv
// K2 execution controller: conditions the board switch/buttons and sequences the
// processor through HALT/RUN/STEP/CLEAR with a single-cycle cpu_en on the system clock.
module k2_exec_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int RATE_W          = 28,
  parameter int RST_CYCLES      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_sw,
  input  logic              step_btn,
  input  logic              clr_btn,
  input  logic [RATE_W-1:0] rate_div,
  input  logic              bp_en,
  input  logic [15:0]       bp_count,
  output logic              cpu_en,
  output logic              cpu_rst_n,
  output logic [15:0]       instr_count,
  output logic [1:0]        state,
  output logic              bp_hit
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

  // Input conditioning: bit 0 = run, bit 1 = step, bit 2 = clear.
  logic [2:0]      raw_in;
  logic [2:0]      sync1, sync2, deb, db_fire;
  logic [DB_W-1:0] db_cnt [3];
  logic            step_req, clr_req, run_deb;

  assign raw_in  = {clr_btn, step_btn, run_sw};
  assign run_deb = deb[0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    db_fire = '0;
    for (int i = 0; i < 3; i++)
      db_fire[i] = (sync2[i] != deb[i]) && (db_cnt[i] == DB_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      step_req <= 1'b0;
      clr_req  <= 1'b0;
      // NOTE: this counter array is three small registers, not a RAM, so it is reset with everything else.
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so the two synchronizer stages shift, not collapse.
      sync1    <= raw_in;
      sync2    <= sync1;
      step_req <= db_fire[1] & sync2[1];
      clr_req  <= db_fire[2] & sync2[2];
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_fire[i]) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Sequencer: next-state and next-output logic; every output is registered below.
  state_t            state_q, state_d;
  logic [RC_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [RATE_W-1:0] rate_cnt_q, rate_cnt_d, rate_last;
  logic              cpu_en_d, bp_hit_d, bp_trig;
  logic [15:0]       count_d;

  assign rate_last = (rate_div == '0) ? '0 : rate_div - 1'b1;
  // The pulse in flight is the one that lands instr_count on bp_count (wraps at 0xFFFF).
  assign bp_trig = (state_q == ST_RUN) && cpu_en && bp_en && ((instr_count + 16'd1) == bp_count);

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    rate_cnt_d = rate_cnt_q;
    cpu_en_d   = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == RC_LAST) state_d = ST_HALT;
        else                      clr_cnt_d = clr_cnt_q + 1'b1;
      end
      ST_HALT: begin
        if (run_deb && !bp_hit) begin
          state_d    = ST_RUN;
          rate_cnt_d = '0;
        end else if (step_req) begin
          state_d  = ST_STEP;
          cpu_en_d = 1'b1;
        end
      end
      ST_STEP: state_d = ST_HALT;
      ST_RUN: begin
        if (!run_deb || bp_trig) begin
          state_d = ST_HALT;
        end else if (rate_cnt_q >= rate_last) begin
          cpu_en_d   = 1'b1;
          rate_cnt_d = '0;
        end else begin
          rate_cnt_d = rate_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    if (clr_req) begin
      state_d   = ST_CLEAR;
      clr_cnt_d = '0;
      cpu_en_d  = 1'b0;
    end

    if (state_d == ST_CLEAR || !run_deb) bp_hit_d = 1'b0;
    else if (bp_trig)                    bp_hit_d = 1'b1;
    else                                 bp_hit_d = bp_hit;

    count_d = (state_d == ST_CLEAR) ? 16'd0 : instr_count + {15'd0, cpu_en};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      rate_cnt_q  <= '0;
      cpu_en      <= 1'b0;
      cpu_rst_n   <= 1'b0;
      instr_count <= '0;
      bp_hit      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rate_cnt_q  <= rate_cnt_d;
      cpu_en      <= cpu_en_d;
      cpu_rst_n   <= (state_d != ST_CLEAR);
      instr_count <= count_d;
      bp_hit      <= bp_hit_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_k2_exec_controller.sv
// Scoreboard bench for k2_exec_controller: stimulus predicts each cpu_en pulse (cycle and
// instruction count) from the behavioural timing rules; a negedge monitor pops and compares.
module tb_k2_exec_controller;

  localparam int D   = 4;
  localparam int RC  = 4;
  localparam int RW  = 8;
  localparam int LAT = D + 3;  // raw input change to FSM state change, in edges

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          run_sw = 1'b0, step_btn = 1'b0, clr_btn = 1'b0, bp_en = 1'b0;
  logic [RW-1:0] rate_div = '0;
  logic [15:0]   bp_count = '0;
  logic          cpu_en, cpu_rst_n, bp_hit;
  logic [15:0]   instr_count;
  logic [1:0]    state;

  k2_exec_controller #(.DEBOUNCE_CYCLES(D), .RATE_W(RW), .RST_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n), .run_sw(run_sw), .step_btn(step_btn), .clr_btn(clr_btn),
    .rate_div(rate_div), .bp_en(bp_en), .bp_count(bp_count), .cpu_en(cpu_en),
    .cpu_rst_n(cpu_rst_n), .instr_count(instr_count), .state(state), .bp_hit(bp_hit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;

  typedef struct {
    int          edge_n;
    logic [15:0] count;
  } pulse_t;
  pulse_t      exp_q[$];
  pulse_t      mon_p;
  logic [15:0] m_count = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic goto(input int e);
    if (e > cyc) begin
      repeat (e - cyc) @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_pulse(input int e);
    exp_q.push_back('{edge_n: e, count: m_count});
    m_count = m_count + 16'd1;
  endtask

  // Run mode entered at edge e with period r: pulses at e+r, e+2r, ... up to stop.
  task automatic run_window(input int e, input int r, input int stop);
    for (int t = e + r; t <= stop; t += r) expect_pulse(t);
  endtask

  always @(negedge clk) begin
    if (cpu_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: cpu_en high at cycle %0d with no pulse pending", cyc);
      end else begin
        mon_p = exp_q.pop_front();
        check("pulse_cycle", cyc, mon_p.edge_n);
        check("pulse_count", instr_count, mon_p.count);
      end
    end
  end

  initial begin
    int n, e, p, k, n2, r, x, nc;

    // Reset values, then the CLEAR sequence after release.
    goto(2);
    check("rst_state", state, 3);
    check("rst_cpu_rst_n", cpu_rst_n, 0);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_count", instr_count, 0);
    check("rst_bp_hit", bp_hit, 0);
    goto(3);
    rst_n = 1'b1;
    goto(3 + RC - 1);
    check("clear_rst_low", cpu_rst_n, 0);
    check("clear_state", state, 3);
    goto(3 + RC);
    check("clear_rst_high", cpu_rst_n, 1);
    check("clear_to_halt", state, 0);
    check("clear_count", instr_count, 0);

    // Single steps with random hold and gap lengths.
    goto(10);
    for (int i = 0; i < 3; i++) begin
      n = cyc;
      step_btn = 1'b1;
      expect_pulse(n + LAT);
      goto(n + int'($urandom_range(8, 12)));
      step_btn = 1'b0;
      goto(cyc + D + int'($urandom_range(6, 10)));
    end
    check("step_count", instr_count, 3);
    n = cyc;
    step_btn = 1'b1;
    goto(n + 2);
    step_btn = 1'b0;
    goto(n + 20);
    check("glitch_count", instr_count, 3);
    check("glitch_state", state, 0);

    // Run at rate 5, switch to rate 0 on a pulse cycle, then drop the run switch.
    rate_div = 8'd5;
    n = cyc;
    run_sw = 1'b1;
    e = n + LAT;
    k = int'($urandom_range(3, 5));
    run_window(e, 5, e + 5 * k);
    p = e + 5 * k;
    goto(p);
    check("run_state", state, 1);
    rate_div = 8'd0;
    n2 = p + int'($urandom_range(3, 8));
    run_window(p, 1, n2 + D + 2);
    goto(n2);
    run_sw = 1'b0;
    goto(n2 + LAT);
    check("run_off_state", state, 0);
    goto(cyc + 10);
    check("run_off_count", instr_count, m_count);

    // Breakpoint seven pulses ahead at rate 2.
    rate_div = 8'd2;
    bp_en = 1'b1;
    bp_count = m_count + 16'd7;
    n = cyc;
    run_sw = 1'b1;
    e = n + LAT;
    run_window(e, 2, e + 14);
    goto(e + 15);
    check("bp_hit_set", bp_hit, 1);
    check("bp_state", state, 0);
    check("bp_count_val", instr_count, bp_count);
    goto(cyc + 10);
    check("bp_stays_halted", state, 0);
    n = cyc;
    step_btn = 1'b1;
    expect_pulse(n + LAT);
    goto(n + 10);
    step_btn = 1'b0;
    check("bp_step_count", instr_count, m_count);
    check("bp_step_hit_kept", bp_hit, 1);
    goto(cyc + 12);
    n = cyc;
    run_sw = 1'b0;
    goto(n + LAT);
    check("bp_hit_cleared", bp_hit, 0);
    goto(cyc + 5);
    n = cyc;
    run_sw = 1'b1;
    e = n + LAT;
    n2 = e + int'($urandom_range(10, 20));
    run_window(e, 2, n2 + D + 2);
    goto(e + 1);
    check("bp_resume_run", state, 1);
    goto(n2);
    run_sw = 1'b0;
    goto(n2 + LAT);
    check("bp_resume_stop", state, 0);

    // Count wrap at rate 1 with a breakpoint at 0x0000.
    goto(cyc + 5);
    rate_div = 8'd1;
    bp_count = 16'd0;
    n = cyc;
    run_sw = 1'b1;
    e = n + LAT;
    x = 65536 - int'(m_count);
    run_window(e, 1, e + x);
    goto(e + x);
    check("wrap_last_ffff", instr_count, 16'hFFFF);
    goto(e + x + 1);
    check("wrap_count_zero", instr_count, 0);
    check("wrap_bp_hit", bp_hit, 1);
    check("wrap_halt", state, 0);

    // Clear pressed mid-run; RUN resumes after CLEAR because run_sw stays high.
    run_sw = 1'b0;
    bp_en = 1'b0;
    goto(cyc + LAT + 3);
    r = int'($urandom_range(3, 6));
    rate_div = RW'(r);
    n = cyc;
    run_sw = 1'b1;
    e = n + LAT;
    nc = e + int'($urandom_range(8, 20));
    run_window(e, r, nc + D + 2);
    goto(nc);
    clr_btn = 1'b1;
    goto(nc + LAT);
    check("clr_state", state, 3);
    check("clr_rst_low", cpu_rst_n, 0);
    check("clr_count", instr_count, 0);
    clr_btn = 1'b0;
    m_count = '0;
    goto(nc + LAT + RC - 1);
    check("clr_rst_still_low", cpu_rst_n, 0);
    goto(nc + LAT + RC);
    check("clr_rst_high", cpu_rst_n, 1);
    check("clr_halt", state, 0);
    goto(nc + LAT + RC + 1);
    check("clr_rerun", state, 1);
    e = nc + LAT + RC + 1;
    x = e + int'($urandom_range(5, 15));
    run_window(e, r, x - 1);

    // Asynchronous reset in the middle of RUN.
    goto(x);
    rst_n = 1'b0;
    #1;
    check("async_state", state, 3);
    check("async_cpu_en", cpu_en, 0);
    check("async_cpu_rst_n", cpu_rst_n, 0);
    check("async_count", instr_count, 0);
    run_sw = 1'b0;
    goto(x + 3);
    rst_n = 1'b1;
    goto(x + 3 + RC - 1);
    check("post_rst_low", cpu_rst_n, 0);
    goto(x + 3 + RC);
    check("post_rst_high", cpu_rst_n, 1);
    check("post_rst_halt", state, 0);

    goto(cyc + 20);
    check("pulses_outstanding", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
